// File: rtl/vrased_pkg.sv
// Shared constants for the VRASED reset sequencer: violation source indices,
// sequencer state encoding and the timer width helper.
package vrased_pkg;

  localparam int SRC_X_STACK  = 0;
  localparam int SRC_AC       = 1;
  localparam int SRC_ATOM     = 2;
  localparam int SRC_DMA_AC   = 3;
  localparam int SRC_DMA_DET  = 4;
  localparam int SRC_DMA_XSTK = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Bits needed to hold max(a,b)-1, never less than one.
  function automatic int tmr_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/vrased_rst_timer.sv
// Loadable down-counter with zero flag; one instance serves both the HOLD
// and DRAIN phases of the reset sequencer.
module vrased_rst_timer #(
  parameter int W = 2
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset)     r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_dec && (r_cnt != '0)) r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/vrased_reset_seq.sv
// Sequences the MCU reset on VRASED monitor violations: immediate assertion,
// minimum hold, quiet-period drain, plus sticky cause / event count / fault PC.
module vrased_reset_seq
  import vrased_pkg::*;
#(
  parameter int NUM_SRC  = 6,
  parameter int RST_HOLD = 4,
  parameter int QUIET    = 2,
  parameter int CNT_W    = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NUM_SRC-1:0] i_viol,
  input  logic [15:0]        i_pc,
  input  logic               i_cause_clr,
  output logic               o_cpu_reset,
  output logic [NUM_SRC-1:0] o_cause,
  output logic [CNT_W-1:0]   o_viol_count,
  output logic [15:0]        o_fault_pc,
  output logic               o_busy
);

  localparam int TW = tmr_w(RST_HOLD, QUIET);
  localparam logic [TW-1:0] HOLD_LD  = TW'(RST_HOLD - 1);
  localparam logic [TW-1:0] QUIET_LD = TW'(QUIET - 1);

  state_t             r_state;
  logic [NUM_SRC-1:0] r_cause;
  logic [CNT_W-1:0]   r_count;
  logic [15:0]        r_fault_pc;

  logic          w_any;
  logic          w_tmr_load;
  logic [TW-1:0] w_tmr_val;
  logic          w_tmr_dec;
  logic          w_tmr_zero;

  assign w_any = |i_viol;

  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = HOLD_LD;
    w_tmr_dec  = 1'b0;
    case (r_state)
      ST_IDLE: w_tmr_load = w_any;
      ST_HOLD: begin
        w_tmr_load = w_tmr_zero;
        w_tmr_val  = QUIET_LD;
        w_tmr_dec  = !w_tmr_zero;
      end
      ST_DRAIN: begin
        w_tmr_load = w_any;
        w_tmr_val  = QUIET_LD;
        w_tmr_dec  = !w_any;
      end
      default: ;
    endcase
  end

  vrased_rst_timer #(.W(TW)) u_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_cause    <= '0;
      r_count    <= '0;
      r_fault_pc <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // A clear pulse coinciding with a violation keeps only the new bits.
          if (i_cause_clr) r_cause <= i_viol;
          else             r_cause <= r_cause | i_viol;
          if (w_any) begin
            r_state    <= ST_HOLD;
            r_fault_pc <= i_pc;
            if (r_count != '1) r_count <= r_count + 1'b1;
          end
        end
        ST_HOLD: begin
          r_cause <= r_cause | i_viol;
          if (w_tmr_zero) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          r_cause <= r_cause | i_viol;
          if (!w_any && w_tmr_zero) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Violation path is purely combinational so the core sees reset in the same cycle.
  assign o_cpu_reset  = i_reset | w_any | (r_state != ST_IDLE);
  assign o_cause      = r_cause;
  assign o_viol_count = r_count;
  assign o_fault_pc   = r_fault_pc;
  assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_vrased_reset_seq.sv
// Directed bench for vrased_reset_seq with default parameters.
module tb_vrased_reset_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  viol = '0;
  logic [15:0] pc = '0;
  logic        cause_clr = 1'b0;
  logic        cpu_reset;
  logic [5:0]  cause;
  logic [7:0]  viol_count;
  logic [15:0] fault_pc;
  logic        busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vrased_reset_seq dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_viol       (viol),
    .i_pc         (pc),
    .i_cause_clr  (cause_clr),
    .o_cpu_reset  (cpu_reset),
    .o_cause      (cause),
    .o_viol_count (viol_count),
    .o_fault_pc   (fault_pc),
    .o_busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    viol = '0;
    cause_clr = 1'b0;
    reset = 1'b1;
    #1 chk("rst_cpu_reset_during", 32'(cpu_reset), 32'd1);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_cpu_reset_after", 32'(cpu_reset), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cause", 32'(cause), 32'd0);
    chk("rst_count", 32'(viol_count), 32'd0);
    chk("rst_fault_pc", 32'(fault_pc), 32'd0);
  endtask

  initial begin
    tick();
    do_reset();

    // 1: isolated one-cycle violation -> 7 cycles of cpu_reset
    tick();
    viol = 6'b000100; pc = 16'hE010;
    #1 chk("t1_cpu_reset_t0", 32'(cpu_reset), 32'd1);
    tick();
    viol = '0; pc = 16'h0100;
    chk("t1_cause", 32'(cause), 32'h04);
    chk("t1_count", 32'(viol_count), 32'd1);
    chk("t1_fault_pc", 32'(fault_pc), 32'hE010);
    chk("t1_busy", 32'(busy), 32'd1);
    for (int i = 1; i <= 6; i++) begin
      #1 chk($sformatf("t1_cpu_reset_t%0d", i), 32'(cpu_reset), 32'd1);
      tick();
    end
    #1 chk("t1_cpu_reset_t7", 32'(cpu_reset), 32'd0);
    chk("t1_busy_end", 32'(busy), 32'd0);

    // 2: violation held 10 cycles -> release 2 cycles after it drops
    do_reset();
    tick();
    viol = 6'b000001; pc = 16'hA000;
    for (int i = 0; i < 10; i++) begin
      tick();
      pc = pc + 16'd2;
    end
    viol = '0;
    #1 chk("t2_cpu_reset_t10", 32'(cpu_reset), 32'd1);
    tick();
    #1 chk("t2_cpu_reset_t11", 32'(cpu_reset), 32'd1);
    tick();
    #1 chk("t2_cpu_reset_t12", 32'(cpu_reset), 32'd0);
    chk("t2_count", 32'(viol_count), 32'd1);
    chk("t2_fault_pc", 32'(fault_pc), 32'hA000);

    // 3: extra source during HOLD adds to cause, does not extend or count
    do_reset();
    tick();
    viol = 6'b101000; pc = 16'h1111;
    tick();
    viol = '0;
    tick();
    viol = 6'b000010;
    tick();
    viol = '0;
    tick(); tick(); tick();
    #1 chk("t3_cpu_reset_t6", 32'(cpu_reset), 32'd1);
    tick();
    #1 chk("t3_cpu_reset_t7", 32'(cpu_reset), 32'd0);
    chk("t3_cause", 32'(cause), 32'h2A);
    chk("t3_count", 32'(viol_count), 32'd1);

    // 4: 300 isolated events -> counter saturates at FF
    for (int i = 0; i < 300; i++) begin
      viol = 6'b000001;
      tick();
      viol = '0;
      repeat (8) tick();
      if (i == 252) chk("t4_count_254", 32'(viol_count), 32'hFE);
      if (i == 253) chk("t4_count_255", 32'(viol_count), 32'hFF);
    end
    chk("t4_count_sat", 32'(viol_count), 32'hFF);
    chk("t4_cause", 32'(cause), 32'h2B);
    chk("t4_busy", 32'(busy), 32'd0);

    // 5: cause_clr behaviour
    viol = 6'b000001; cause_clr = 1'b1; pc = 16'h5555;
    tick();
    viol = '0; cause_clr = 1'b0;
    chk("t5_clr_with_viol", 32'(cause), 32'h01);
    chk("t5_fault_pc", 32'(fault_pc), 32'h5555);
    repeat (4) tick();
    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;
    chk("t5_clr_in_drain", 32'(cause), 32'h01);
    chk("t5_busy_drain", 32'(busy), 32'd1);
    tick();
    chk("t5_idle", 32'(busy), 32'd0);
    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;
    chk("t5_clr_idle", 32'(cause), 32'h00);
    chk("t5_count_kept", 32'(viol_count), 32'hFF);
    chk("t5_fault_pc_kept", 32'(fault_pc), 32'h5555);

    // 6: reset pulse mid-HOLD
    viol = 6'b010000; pc = 16'h1234;
    tick();
    viol = '0;
    tick();
    chk("t6_busy_hold", 32'(busy), 32'd1);
    reset = 1'b1;
    #1 chk("t6_cpu_reset_in_rst", 32'(cpu_reset), 32'd1);
    tick();
    reset = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_cause", 32'(cause), 32'd0);
    chk("t6_count", 32'(viol_count), 32'd0);
    chk("t6_fault_pc", 32'(fault_pc), 32'd0);
    chk("t6_cpu_reset_after", 32'(cpu_reset), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
